// File: rtl/axi_bus_pkg.sv
// Shared types for the two-requester AXI bridge arbiter.
package axi_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_STRB_W = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    // Request payload held toward the bridge for the whole transaction.
    typedef struct packed {
        logic                  write;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_STRB_W-1:0] wstrb;
    } bus_req_t;

    // Counter width able to hold 0..max_streak inclusive.
    function automatic int unsigned streak_w(input int unsigned max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/arb_streak_ctr.sv
// Grant decision with a saturating data-streak counter that bounds inst starvation.
module arb_streak_ctr
    import axi_bus_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic evaluate,
    input  logic inst_pend,
    input  logic data_pend,
    output logic grant_inst_c,
    output logic grant_data_c
);

    localparam int unsigned CNT_W = streak_w(MAX_DATA_STREAK);

    logic [CNT_W-1:0] streak;
    logic             at_limit;

    assign at_limit = (streak >= CNT_W'(MAX_DATA_STREAK));

    // Data wins by default; inst wins alone or once data has used its streak.
    always_comb begin
        grant_inst_c = 1'b0;
        grant_data_c = 1'b0;
        if (evaluate) begin
            if (inst_pend && (!data_pend || at_limit)) begin
                grant_inst_c = 1'b1;
            end else if (data_pend) begin
                grant_data_c = 1'b1;
            end
        end
    end

    // Streak counts only data grants taken while inst is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (grant_inst_c) begin
            streak <= '0;
        end else if (grant_data_c) begin
            streak <= inst_pend ? (streak + CNT_W'(1)) : '0;
        end
    end

endmodule

// File: rtl/axi_sram_arbiter.sv
// Serialises inst-fetch and data requests onto a single AXI4 master bridge.
module axi_sram_arbiter
    import axi_bus_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // instruction fetch port
    input  logic                  inst_rd_en,
    input  logic [ADDR_W-1:0]     inst_rd_addr,
    output logic                  inst_rd_valid,
    output logic [DATA_W-1:0]     inst_rd_data,
    // data access port
    input  logic                  data_rd_en,
    input  logic                  data_wr_en,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wr_data,
    input  logic [DATA_W/8-1:0]   data_wr_strb,
    output logic                  data_rd_valid,
    output logic [DATA_W-1:0]     data_rd_data,
    output logic                  data_wr_done,
    // bridge side
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_req_write,
    output logic [ADDR_W-1:0]     bus_req_addr,
    output logic [DATA_W-1:0]     bus_req_wdata,
    output logic [DATA_W/8-1:0]   bus_req_wstrb,
    input  logic                  bus_resp_valid,
    input  logic [DATA_W-1:0]     bus_resp_data
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e state;
    owner_e     owner;
    bus_req_t   req_q;

    logic evaluate;
    logic inst_pend;
    logic data_pend;
    logic grant_inst_c;
    logic grant_data_c;
    logic pulse_active;

    assign inst_pend    = inst_rd_en;
    assign data_pend    = data_rd_en | data_wr_en;
    assign pulse_active = inst_rd_valid | data_rd_valid | data_wr_done;

    // The completion-pulse cycle is dead: requesters still show the old level then.
    assign evaluate = (state == IDLE) && !pulse_active;

    arb_streak_ctr #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_streak (
        .clk          (ACLK),
        .rst_n        (ARESETn),
        .evaluate     (evaluate),
        .inst_pend    (inst_pend),
        .data_pend    (data_pend),
        .grant_inst_c (grant_inst_c),
        .grant_data_c (grant_data_c)
    );

    // Request fields are driven straight from the payload captured at grant.
    assign bus_req_write = req_q.write;
    assign bus_req_addr  = ADDR_W'(req_q.addr);
    assign bus_req_wdata = DATA_W'(req_q.wdata);
    assign bus_req_wstrb = STRB_W'(req_q.wstrb);

    // Arbitration FSM: capture on grant, hold through handshake, route the response.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state         <= IDLE;
            owner         <= OWN_NONE;
            req_q         <= '0;
            bus_req_valid <= 1'b0;
            inst_rd_valid <= 1'b0;
            inst_rd_data  <= '0;
            data_rd_valid <= 1'b0;
            data_rd_data  <= '0;
            data_wr_done  <= 1'b0;
        end else begin
            inst_rd_valid <= 1'b0;
            data_rd_valid <= 1'b0;
            data_wr_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_inst_c) begin
                        owner         <= OWN_INST;
                        req_q.write   <= 1'b0;
                        req_q.addr    <= BUS_ADDR_W'(inst_rd_addr);
                        req_q.wdata   <= '0;
                        req_q.wstrb   <= '0;
                        bus_req_valid <= 1'b1;
                        state         <= REQ;
                    end else if (grant_data_c) begin
                        // A simultaneous read and write is resolved as the write.
                        owner         <= OWN_DATA;
                        req_q.write   <= data_wr_en;
                        req_q.addr    <= BUS_ADDR_W'(data_addr);
                        req_q.wdata   <= data_wr_en ? BUS_DATA_W'(data_wr_data) : '0;
                        req_q.wstrb   <= data_wr_en ? BUS_STRB_W'(data_wr_strb) : '0;
                        bus_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_resp_valid) begin
                        case (owner)
                            OWN_INST: begin
                                inst_rd_valid <= 1'b1;
                                inst_rd_data  <= bus_resp_data;
                            end
                            OWN_DATA: begin
                                if (req_q.write) begin
                                    data_wr_done <= 1'b1;
                                end else begin
                                    data_rd_valid <= 1'b1;
                                    data_rd_data  <= bus_resp_data;
                                end
                            end
                            default: begin
                            end
                        endcase
                        owner <= OWN_NONE;
                        state <= IDLE;
                    end
                end
                default: begin
                    bus_req_valid <= 1'b0;
                    owner         <= OWN_NONE;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_sram_arbiter.md
Name: axi_sram_arbiter

Overview:
- Shares the single AXI4 master bridge between two core-side requesters: instruction fetch (read-only) and data access (read/write).
- Sits between the IF/MEM stages and the AXI4 master bridge.
- Serialises requests: one transaction in flight at a time.
- Default priority goes to data. A starvation counter guarantees instruction fetch eventually wins.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DATA_STREAK, 4, consecutive data grants allowed while an inst request waits; must be >= 1

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- inst_rd_en  in  1  inst read request level, held until inst_rd_valid
- inst_rd_addr  in  ADDR_W  inst read address
- inst_rd_valid  out  1  one-cycle pulse: inst_rd_data valid
- inst_rd_data  out  DATA_W  inst read data
- data_rd_en  in  1  data read request level, held until data_rd_valid
- data_wr_en  in  1  data write request level, held until data_wr_done
- data_addr  in  ADDR_W  data address
- data_wr_data  in  DATA_W  write data
- data_wr_strb  in  DATA_W/8  byte strobes
- data_rd_valid  out  1  one-cycle pulse: data_rd_data valid
- data_rd_data  out  DATA_W  data read data
- data_wr_done  out  1  one-cycle pulse: write response received
- bus_req_valid  out  1  request to bridge
- bus_req_ready  in  1  bridge accepts request
- bus_req_write  out  1  1 = write
- bus_req_addr  out  ADDR_W  request address
- bus_req_wdata  out  DATA_W  write data
- bus_req_wstrb  out  DATA_W/8  strobes
- bus_resp_valid  in  1  response pulse from bridge
- bus_resp_data  in  DATA_W  read response data

Behaviour:
- Reset, asynchronous on ARESETn low:
  - state = IDLE, streak = 0, owner = NONE.
  - All valid/done outputs = 0; all data/addr outputs = 0.
- Reset mid-transaction aborts it. The bridge is reset by the same ARESETn.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Evaluate requests.
  - data_wr_en and data_rd_en both high is illegal; write wins.
  - Arbitration:
    - Only inst pending -> grant inst.
    - Only data pending -> grant data.
    - Both pending and streak < MAX_DATA_STREAK -> grant data, streak += 1.
    - Both pending and streak == MAX_DATA_STREAK -> grant inst.
  - Any inst grant clears streak. A data grant with no inst pending also clears streak.
  - On grant:
    - Register owner, write flag, addr, wdata and wstrb into bus_req_* (strb = 0 for reads).
    - Assert bus_req_valid next cycle; go to REQ.
  - No request -> stay in IDLE.
- REQ:
  - bus_req_valid = 1 and all bus_req_* fields stable.
  - On bus_req_ready: bus_req_valid <= 0, go to WAIT.
  - Same-cycle bus_resp_valid is not legal from the bridge.
- WAIT:
  - On bus_resp_valid, route by owner, then go to IDLE next cycle:
    - inst -> inst_rd_valid = 1 and inst_rd_data = bus_resp_data, registered (one cycle after resp).
    - data read -> data_rd_valid and data_rd_data, same timing.
    - data write -> data_wr_done.
  - Responses only update data outputs for the owner; read data outputs hold their last value otherwise.
- Latency:
  - Request level to bus_req_valid: 1 cycle.
  - bus_resp_valid to requester pulse: 1 cycle.
  - Minimum request-to-response: bridge latency + 2.
- A requester deasserts its enable in the cycle after its valid/done pulse. IDLE therefore sees the updated level. One dead IDLE cycle exists between back-to-back transactions; a requester re-raising immediately is granted then.
- Requester address/data must be stable while its enable is high; the arbiter samples them only at grant.
- Enable dropped by a requester after grant: the transaction still completes and the pulse is still issued.

Decomposition:
- Shared package axi_bus_pkg holds:
  - typedef arb_state_e {IDLE, REQ, WAIT}
  - typedef owner_e {OWN_NONE, OWN_INST, OWN_DATA}
  - struct bus_req_t {write, addr, wdata, wstrb}
- One natural sub-module: arb_streak_ctr. It holds the saturating streak counter and the grant decision (combinational grant + registered count).

Test Plan:
- Single inst read:
  - Stimulus: inst_rd_en, addr 0x1C000000; bridge returns 0xDEADBEEF after 3 cycles.
  - Required: bus_req_write=0, addr 0x1C000000; inst_rd_valid pulses once with 0xDEADBEEF; data outputs unchanged.
- Data write:
  - Stimulus: data_wr_en, addr 0x80, wdata 0x12345678, strb 0xF.
  - Required: bus_req_write=1 with the same fields held through bus_req_ready stalled 5 cycles; data_wr_done pulses once after resp.
- Contention, MAX_DATA_STREAK=4:
  - Stimulus: inst and data requests held high continuously.
  - Required: grant order D,D,D,D,I,D,D,D,D,I.
- Simultaneous rd+wr:
  - Stimulus: data_rd_en and data_wr_en both high.
  - Required: write issued, data_wr_done only; no data_rd_valid.
- Reset mid-operation:
  - Stimulus: ARESETn low during WAIT (asynchronous, mid-cycle).
  - Required: outputs 0 immediately; after release, a fresh inst read completes normally with streak = 0.
- Back-pressure:
  - Stimulus: bus_req_ready low for 10 cycles.
  - Required: no grant change; owner and fields stable; exactly one response routed.
